// File: rtl/bcd_counter_chain_if.sv
// Control/data bundle for the cascaded BCD counter: count controls and load value in, count and status out.
// No handshake; every field is sampled or updated on each rising clock edge.
interface bcd_counter_chain_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [4*DIGITS-1:0]   z;
  logic                  tc;
  logic                  ovf;

  modport master (
    output en, up, clr, load, din,
    input  z, tc, ovf
  );

  modport slave (
    input  en, up, clr, load, din,
    output z, tc, ovf
  );
endinterface

// File: rtl/bcd_counter_chain.sv
// Up/down chain of DIGITS decimal counters with clear, load, wrap or saturate at the limits.
// One-cycle latency to z and ovf, tc combinational; no backpressure, the count advances on every enabled edge.
module bcd_counter_chain #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic                x,
  input logic                reset,
  bcd_counter_chain_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] z_q;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] load_val;
  logic         ovf_q;
  logic         at_max;
  logic         at_min;
  logic         tc;
  logic         ripple;

  always_comb begin
    at_max = 1'b1;
    at_min = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (z_q[4*k +: 4] != 4'd9) at_max = 1'b0;
      if (z_q[4*k +: 4] != 4'd0) at_min = 1'b0;
    end
  end

  assign tc = bus.en & (bus.up ? at_max : at_min);

  // Carry/borrow enters digit 0 and keeps rippling only through digits sitting at 9 (up) or 0 (down).
  always_comb begin
    cnt_nxt = z_q;
    ripple  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (ripple) begin
        if (bus.up) begin
          if (z_q[4*k +: 4] == 4'd9) begin
            cnt_nxt[4*k +: 4] = 4'd0;
          end else begin
            cnt_nxt[4*k +: 4] = z_q[4*k +: 4] + 4'd1;
            ripple            = 1'b0;
          end
        end else begin
          if (z_q[4*k +: 4] == 4'd0) begin
            cnt_nxt[4*k +: 4] = 4'd9;
          end else begin
            cnt_nxt[4*k +: 4] = z_q[4*k +: 4] - 4'd1;
            ripple            = 1'b0;
          end
        end
      end
    end
    if (SATURATE && tc) cnt_nxt = z_q;
  end

  always_comb begin
    load_val = '0;
    for (int k = 0; k < DIGITS; k++) begin
      load_val[4*k +: 4] = (bus.din[4*k +: 4] > 4'd9) ? 4'd0 : bus.din[4*k +: 4];
    end
  end

  always_ff @(posedge x or negedge reset) begin
    if (!reset) begin
      z_q   <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clr) begin
      z_q   <= '0;
      ovf_q <= 1'b0;
    end else if (bus.load) begin
      z_q   <= load_val;
      ovf_q <= 1'b0;
    end else if (bus.en) begin
      z_q   <= cnt_nxt;
      ovf_q <= tc;
    end else begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.z   = z_q;
  assign bus.tc  = tc;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_bcd_counter_chain.sv
// Bench for two DIGITS=2 counters (wrap and saturate) driven in lockstep and compared with a decimal-integer model.
module tb_bcd_counter_chain;
  localparam int DIGITS = 2;

  logic       x = 1'b0;
  logic       reset;
  logic       en, up, clr, load;
  logic [7:0] din;

  bcd_counter_chain_if #(.DIGITS(DIGITS)) bif0 ();
  bcd_counter_chain_if #(.DIGITS(DIGITS)) bif1 ();

  assign bif0.en = en;   assign bif1.en = en;
  assign bif0.up = up;   assign bif1.up = up;
  assign bif0.clr = clr; assign bif1.clr = clr;
  assign bif0.load = load; assign bif1.load = load;
  assign bif0.din = din; assign bif1.din = din;

  bcd_counter_chain #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut0 (.x(x), .reset(reset), .bus(bif0.slave));
  bcd_counter_chain #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut1 (.x(x), .reset(reset), .bus(bif1.slave));

  always #5 x = ~x;

  int   errors = 0;
  int   checks = 0;
  int   m_v[2];
  logic m_ovf[2];

  typedef struct {
    logic       clr, load, en, up;
    logic [7:0] din;
    logic [7:0] ez;
    logic       eovf;
    logic       etc;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic model_tc(input int i);
    return en && (up ? (m_v[i] == 99) : (m_v[i] == 0));
  endfunction

  // Model works on plain integers 0..99; digits only appear when converting for comparison.
  task automatic model_edge();
    int hi, lo;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_v[i] = 0; m_ovf[i] = 1'b0;
      end else if (load) begin
        hi = (din[7:4] > 9) ? 0 : int'(din[7:4]);
        lo = (din[3:0] > 9) ? 0 : int'(din[3:0]);
        m_v[i] = hi * 10 + lo; m_ovf[i] = 1'b0;
      end else if (en) begin
        m_ovf[i] = model_tc(i);
        if (up) begin
          if (m_v[i] == 99) m_v[i] = (i == 1) ? 99 : 0;
          else m_v[i] = m_v[i] + 1;
        end else begin
          if (m_v[i] == 0) m_v[i] = (i == 1) ? 0 : 99;
          else m_v[i] = m_v[i] - 1;
        end
      end else begin
        m_ovf[i] = 1'b0;
      end
    end
  endtask

  task automatic set_in(input logic c, input logic l, input logic e, input logic u, input logic [7:0] d);
    clr = c; load = l; en = e; up = u; din = d;
  endtask

  task automatic step(input string tag);
    #1;
    chk({tag, " tc0"}, 32'(bif0.tc), 32'(model_tc(0)));
    chk({tag, " tc1"}, 32'(bif1.tc), 32'(model_tc(1)));
    @(posedge x);
    model_edge();
    #1;
    chk({tag, " z0"}, 32'(bif0.z), 32'(to_bcd(m_v[0])));
    chk({tag, " ovf0"}, 32'(bif0.ovf), 32'(m_ovf[0]));
    chk({tag, " z1"}, 32'(bif1.z), 32'(to_bcd(m_v[1])));
    chk({tag, " ovf1"}, 32'(bif1.ovf), 32'(m_ovf[1]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_ovf[i] = 1'b0;
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA7, 8'h07, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h35, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h99, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h09, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h9F, 8'h90, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h91, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFA, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

    // Reset with junk on the inputs: they must be ignored.
    reset = 1'b0;
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    model_reset();
    repeat (2) @(posedge x);
    #1;
    chk("rst z0", 32'(bif0.z), 32'h0);
    chk("rst ovf0", 32'(bif0.ovf), 32'h0);
    chk("rst z1", 32'(bif1.z), 32'h0);
    chk("rst ovf1", 32'(bif1.ovf), 32'h0);
    @(negedge x);
    reset = 1'b1;

    foreach (tbl[n]) begin
      set_in(tbl[n].clr, tbl[n].load, tbl[n].en, tbl[n].up, tbl[n].din);
      #1;
      chk($sformatf("tbl%0d tc", n), 32'(bif0.tc), 32'(tbl[n].etc));
      step($sformatf("tbl%0d", n));
      chk($sformatf("tbl%0d z", n), 32'(bif0.z), 32'(tbl[n].ez));
      chk($sformatf("tbl%0d ovf", n), 32'(bif0.ovf), 32'(tbl[n].eovf));
    end

    // Full sweep 00..99 and wrap back to 00.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step("sweep clr");
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int k = 1; k <= 100; k++) begin
      step("sweep");
      chk($sformatf("sweep%0d z", k), 32'(bif0.z), 32'(to_bcd(k % 100)));
      chk($sformatf("sweep%0d ovf", k), 32'(bif0.ovf), 32'(k == 100));
    end

    // Saturating instance held at 99.
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
    step("sat load");
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step("sat up");
      chk("sat z", 32'(bif1.z), 32'h99);
      chk("sat ovf", 32'(bif1.ovf), 32'h1);
      chk("sat tc", 32'(bif1.tc), 32'h1);
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step("sat down");
    chk("sat down z", 32'(bif1.z), 32'h98);
    chk("sat down ovf", 32'(bif1.ovf), 32'h0);

    // Asynchronous reset in the middle of a counting cycle.
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h42);
    step("arst load");
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst z0", 32'(bif0.z), 32'h0);
    chk("arst ovf0", 32'(bif0.ovf), 32'h0);
    chk("arst z1", 32'(bif1.z), 32'h0);
    @(posedge x);
    #1;
    chk("arst hold z0", 32'(bif0.z), 32'h0);
    @(negedge x);
    reset = 1'b1;
    step("arst release");
    chk("arst first z", 32'(bif0.z), 32'h01);

    // Randomised traffic, biased so the limits are reached.
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
             1'($urandom_range(1)),
             ($urandom_range(3) == 0) ? 8'h99 : ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
